// File: rtl/e_pipe_reg.sv
// Execute-stage pipeline register for a Y86-64 style pipeline.
// Holds the instruction handed over by decode and derives the ALU operands,
// the ALU function select and the condition-code write enable from it.
module e_pipe_reg #(
   parameter int unsigned W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         bubble,
   input  logic [2:0]   d_stat,
   input  logic [3:0]   d_icode,
   input  logic [3:0]   d_ifun,
   input  logic [W-1:0] d_valC,
   input  logic [W-1:0] d_valA,
   input  logic [W-1:0] d_valB,
   input  logic [3:0]   d_dstE,
   input  logic [3:0]   d_dstM,
   input  logic [3:0]   d_srcA,
   input  logic [3:0]   d_srcB,
   input  logic         m_exc,
   input  logic         w_exc,
   output logic [2:0]   E_stat,
   output logic [3:0]   E_icode,
   output logic [3:0]   E_ifun,
   output logic [W-1:0] E_valC,
   output logic [W-1:0] E_valA,
   output logic [W-1:0] E_valB,
   output logic [3:0]   E_dstE,
   output logic [3:0]   E_dstM,
   output logic [3:0]   E_srcA,
   output logic [3:0]   E_srcB,
   output logic [W-1:0] aluA,
   output logic [W-1:0] aluB,
   output logic [1:0]   alufun,
   output logic         set_cc
);

   // Instruction codes
   localparam logic [3:0] IHalt   = 4'h0;
   localparam logic [3:0] INop    = 4'h1;
   localparam logic [3:0] IRrmovq = 4'h2;
   localparam logic [3:0] IIrmovq = 4'h3;
   localparam logic [3:0] IRmmovq = 4'h4;
   localparam logic [3:0] IMrmovq = 4'h5;
   localparam logic [3:0] IOpq    = 4'h6;
   localparam logic [3:0] IJxx    = 4'h7;
   localparam logic [3:0] ICall   = 4'h8;
   localparam logic [3:0] IRet    = 4'h9;
   localparam logic [3:0] IPushq  = 4'hA;
   localparam logic [3:0] IPopq   = 4'hB;

   // Register ID meaning "no register"
   localparam logic [3:0] RNone   = 4'hF;

   // Status codes
   localparam logic [2:0] SAok    = 3'd1;
   localparam logic [2:0] SAdr    = 3'd2;
   localparam logic [2:0] SIns    = 3'd3;
   localparam logic [2:0] SHlt    = 3'd4;

   // Stack pointer adjustment constants
   localparam logic [W-1:0] ConstPos8 = W'(8);
   localparam logic [W-1:0] ConstNeg8 = -W'(8);

   // Registered E contents
   logic [2:0]   r_stat;
   logic [3:0]   r_icode;
   logic [3:0]   r_ifun;
   logic [W-1:0] r_valC;
   logic [W-1:0] r_valA;
   logic [W-1:0] r_valB;
   logic [3:0]   r_dstE;
   logic [3:0]   r_dstM;
   logic [3:0]   r_srcA;
   logic [3:0]   r_srcB;

   // Decoded operand selects
   logic         w_is_opq;
   logic [W-1:0] w_alu_a;
   logic [W-1:0] w_alu_b;
   logic [1:0]   w_alufun;
   logic         w_set_cc;

   // Pipeline register update: reset > stall > bubble > load.
   // Reset and bubble share the NOP state so a restart looks like an empty slot.
   always_ff @(posedge clk) begin
      if (reset || (!stall && bubble)) begin
         r_stat  <= SAok;
         r_icode <= INop;
         r_ifun  <= 4'h0;
         r_valC  <= '0;
         r_valA  <= '0;
         r_valB  <= '0;
         r_dstE  <= RNone;
         r_dstM  <= RNone;
         r_srcA  <= RNone;
         r_srcB  <= RNone;
      end else if (!stall) begin
         r_stat  <= d_stat;
         r_icode <= d_icode;
         r_ifun  <= d_ifun;
         r_valC  <= d_valC;
         r_valA  <= d_valA;
         r_valB  <= d_valB;
         r_dstE  <= d_dstE;
         r_dstM  <= d_dstM;
         r_srcA  <= d_srcA;
         r_srcB  <= d_srcB;
      end
   end

   assign w_is_opq = (r_icode == IOpq);

   // ALU A operand: register value, immediate, or stack pointer step
   always_comb begin
      w_alu_a = '0;
      case (r_icode)
         IRrmovq, IOpq:             w_alu_a = r_valA;
         IIrmovq, IRmmovq, IMrmovq: w_alu_a = r_valC;
         ICall, IPushq:             w_alu_a = ConstNeg8;
         IRet, IPopq:               w_alu_a = ConstPos8;
         default:                   w_alu_a = '0;
      endcase
   end

   // ALU B operand: base register for memory/stack ops and OPq, else zero
   always_comb begin
      w_alu_b = '0;
      case (r_icode)
         IRmmovq, IMrmovq, IOpq,
         ICall, IPushq, IRet, IPopq: w_alu_b = r_valB;
         default:                    w_alu_b = '0;
      endcase
   end

   // Function select and CC enable; exceptions further down the pipe
   // must block CC updates in the same cycle, so no register here.
   always_comb begin
      w_alufun = 2'd0;
      w_set_cc = 1'b0;
      if (w_is_opq) begin
         w_alufun = r_ifun[1:0];
         w_set_cc = !m_exc && !w_exc;
      end
   end

   assign E_stat  = r_stat;
   assign E_icode = r_icode;
   assign E_ifun  = r_ifun;
   assign E_valC  = r_valC;
   assign E_valA  = r_valA;
   assign E_valB  = r_valB;
   assign E_dstE  = r_dstE;
   assign E_dstM  = r_dstM;
   assign E_srcA  = r_srcA;
   assign E_srcB  = r_srcB;

   assign aluA    = w_alu_a;
   assign aluB    = w_alu_b;
   assign alufun  = w_alufun;
   assign set_cc  = w_set_cc;

   // Codes listed for readability of the decode; not all appear in a case arm
   logic [3:0] w_unused_codes;
   logic [2:0] w_unused_stats;
   assign w_unused_codes = IHalt ^ IJxx;
   assign w_unused_stats = SAdr ^ SIns ^ SHlt;

endmodule

// File: tb/tb_e_pipe_reg.sv
// Scoreboard bench for e_pipe_reg: a driver applies directed vectors and
// queues the hand-computed outputs; a monitor compares them at negedge.
module tb_e_pipe_reg;

   localparam int W = 64;
   localparam int N = 25;

   logic         clk;
   logic         reset, stall, bubble;
   logic [2:0]   d_stat;
   logic [3:0]   d_icode, d_ifun;
   logic [W-1:0] d_valC, d_valA, d_valB;
   logic [3:0]   d_dstE, d_dstM, d_srcA, d_srcB;
   logic         m_exc, w_exc;
   logic [2:0]   E_stat;
   logic [3:0]   E_icode, E_ifun;
   logic [W-1:0] E_valC, E_valA, E_valB;
   logic [3:0]   E_dstE, E_dstM, E_srcA, E_srcB;
   logic [W-1:0] aluA, aluB;
   logic [1:0]   alufun;
   logic         set_cc;

   int n_tests;
   int n_fail;

   typedef struct packed {
      logic         rst;
      logic         stl;
      logic         bub;
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [63:0]  valc;
      logic [63:0]  vala;
      logic [63:0]  valb;
      logic [15:0]  regs;  // {dstE, dstM, srcA, srcB}
      logic         mexc;
      logic         wexc;
   } stim_t;

   typedef struct packed {
      int           id;
      logic [2:0]   stat;
      logic [3:0]   icode;
      logic [3:0]   ifun;
      logic [63:0]  valc;
      logic [63:0]  vala;
      logic [63:0]  valb;
      logic [15:0]  regs;
      logic [63:0]  alua;
      logic [63:0]  alub;
      logic [1:0]   alufun;
      logic         setcc;
   } exp_t;

   stim_t st[N];
   exp_t  ex[N];
   exp_t  sb_q[$];

   e_pipe_reg #(.W(W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
      .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
      .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
      .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
      .m_exc(m_exc), .w_exc(w_exc),
      .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
      .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
      .aluA(aluA), .aluB(aluB), .alufun(alufun), .set_cc(set_cc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic stim_t S(logic r, logic s, logic b, logic [2:0] stat,
                               logic [3:0] ic, logic [3:0] fn, logic [63:0] vc,
                               logic [63:0] va, logic [63:0] vb, logic [15:0] rg,
                               logic me, logic we);
      S = '{rst: r, stl: s, bub: b, stat: stat, icode: ic, ifun: fn, valc: vc,
            vala: va, valb: vb, regs: rg, mexc: me, wexc: we};
   endfunction

   function automatic exp_t X(logic [2:0] stat, logic [3:0] ic, logic [3:0] fn,
                              logic [63:0] vc, logic [63:0] va, logic [63:0] vb,
                              logic [15:0] rg, logic [63:0] aa, logic [63:0] ab,
                              logic [1:0] af, logic sc);
      X = '{id: 0, stat: stat, icode: ic, ifun: fn, valc: vc, vala: va, valb: vb,
            regs: rg, alua: aa, alub: ab, alufun: af, setcc: sc};
   endfunction

   // Monitor: every queued expectation is checked on the falling edge
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         logic [218:0] got_e, req_e;
         logic [130:0] got_o, req_o;
         e = sb_q.pop_front();
         got_e = {E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
                  E_dstE, E_dstM, E_srcA, E_srcB};
         req_e = {e.stat, e.icode, e.ifun, e.valc, e.vala, e.valb, e.regs};
         got_o = {aluA, aluB, alufun, set_cc};
         req_o = {e.alua, e.alub, e.alufun, e.setcc};
         n_tests++;
         if (got_e !== req_e) begin
            n_fail++;
            $display("FAIL vec%0d E_regs: got %h want %h", e.id, got_e, req_e);
         end
         n_tests++;
         if (got_o !== req_o) begin
            n_fail++;
            $display("FAIL vec%0d alu_ctl {aluA,aluB,alufun,set_cc}: got %h want %h",
                     e.id, got_o, req_o);
         end
      end
   end

   localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;

   initial begin
      exp_t bub_e;
      exp_t cur;
      n_tests = 0;
      n_fail  = 0;
      bub_e = X(3'd1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 16'hFFFF, 64'h0, 64'h0, 2'd0, 1'b0);

      // reset with OPQ garbage on the inputs
      st[0]  = S(1,0,0, 3'd1,4'h6,4'h1, 64'h7, 64'h5, 64'h9, 16'h3F23, 0,0);
      ex[0]  = bub_e;
      // OPQ ifun=1 valA=5 valB=9
      st[1]  = S(0,0,0, 3'd1,4'h6,4'h1, 64'h0, 64'h5, 64'h9, 16'h3F23, 0,0);
      ex[1]  = X(3'd1,4'h6,4'h1, 64'h0, 64'h5, 64'h9, 16'h3F23, 64'h5, 64'h9, 2'd1, 1);
      // hold with m_exc, then w_exc, then none: set_cc follows exceptions
      st[2]  = S(0,1,0, 3'd2,4'h2,4'h0, 64'h1, 64'h2, 64'h3, 16'h1111, 1,0);
      ex[2]  = X(3'd1,4'h6,4'h1, 64'h0, 64'h5, 64'h9, 16'h3F23, 64'h5, 64'h9, 2'd1, 0);
      st[3]  = S(0,1,0, 3'd2,4'h2,4'h0, 64'h1, 64'h2, 64'h3, 16'h1111, 0,1);
      ex[3]  = X(3'd1,4'h6,4'h1, 64'h0, 64'h5, 64'h9, 16'h3F23, 64'h5, 64'h9, 2'd1, 0);
      st[4]  = S(0,1,0, 3'd2,4'h2,4'h0, 64'h1, 64'h2, 64'h3, 16'h1111, 0,0);
      ex[4]  = X(3'd1,4'h6,4'h1, 64'h0, 64'h5, 64'h9, 16'h3F23, 64'h5, 64'h9, 2'd1, 1);
      // PUSHQ valB=0x100, then three stalls with changing inputs
      st[5]  = S(0,0,0, 3'd1,4'hA,4'h0, 64'h0, 64'h7, 64'h100, 16'h4F74, 0,0);
      ex[5]  = X(3'd1,4'hA,4'h0, 64'h0, 64'h7, 64'h100, 16'h4F74, M8, 64'h100, 2'd0, 0);
      st[6]  = S(0,1,0, 3'd1,4'h6,4'h2, 64'hAA, 64'hBB, 64'hCC, 16'h1234, 0,0);
      ex[6]  = ex[5];
      st[7]  = S(0,1,0, 3'd3,4'h3,4'h0, 64'h11, 64'h22, 64'h33, 16'h5678, 0,0);
      ex[7]  = ex[5];
      st[8]  = S(0,1,0, 3'd4,4'h9,4'h0, 64'h44, 64'h55, 64'h66, 16'h9ABC, 0,0);
      ex[8]  = ex[5];
      // stall wins over bubble; then bubble alone loads a NOP
      st[9]  = S(0,1,1, 3'd1,4'h6,4'h0, 64'h1, 64'h1, 64'h1, 16'h1111, 0,0);
      ex[9]  = ex[5];
      st[10] = S(0,0,1, 3'd1,4'h6,4'h0, 64'h1, 64'h1, 64'h1, 16'h1111, 0,0);
      ex[10] = bub_e;
      // MRMOVQ then RET
      st[11] = S(0,0,0, 3'd1,4'h5,4'h0, 64'h18, 64'h0, 64'h20, 16'hF5F4, 0,0);
      ex[11] = X(3'd1,4'h5,4'h0, 64'h18, 64'h0, 64'h20, 16'hF5F4, 64'h18, 64'h20, 2'd0, 0);
      st[12] = S(0,0,0, 3'd1,4'h9,4'h0, 64'h0, 64'h30, 64'h40, 16'h4F44, 0,0);
      ex[12] = X(3'd1,4'h9,4'h0, 64'h0, 64'h30, 64'h40, 16'h4F44, 64'h8, 64'h40, 2'd0, 0);
      // RRMOVQ, IRMOVQ, RMMOVQ, CALL, POPQ operand selection
      st[13] = S(0,0,0, 3'd1,4'h2,4'h0, 64'h9, 64'h11, 64'h22, 16'h3F1F, 0,0);
      ex[13] = X(3'd1,4'h2,4'h0, 64'h9, 64'h11, 64'h22, 16'h3F1F, 64'h11, 64'h0, 2'd0, 0);
      st[14] = S(0,0,0, 3'd1,4'h3,4'h0, 64'h33, 64'h1, 64'h44, 16'h2FFF, 0,0);
      ex[14] = X(3'd1,4'h3,4'h0, 64'h33, 64'h1, 64'h44, 16'h2FFF, 64'h33, 64'h0, 2'd0, 0);
      st[15] = S(0,0,0, 3'd1,4'h4,4'h0, 64'h55, 64'h2, 64'h66, 16'hFF12, 0,0);
      ex[15] = X(3'd1,4'h4,4'h0, 64'h55, 64'h2, 64'h66, 16'hFF12, 64'h55, 64'h66, 2'd0, 0);
      st[16] = S(0,0,0, 3'd1,4'h8,4'h0, 64'h300, 64'h3, 64'h80, 16'h4FF4, 0,0);
      ex[16] = X(3'd1,4'h8,4'h0, 64'h300, 64'h3, 64'h80, 16'h4FF4, M8, 64'h80, 2'd0, 0);
      st[17] = S(0,0,0, 3'd1,4'hB,4'h0, 64'h0, 64'h90, 64'h90, 16'h4644, 0,0);
      ex[17] = X(3'd1,4'hB,4'h0, 64'h0, 64'h90, 64'h90, 16'h4644, 64'h8, 64'h90, 2'd0, 0);
      // OPQ ifun=3 with write-back exception
      st[18] = S(0,0,0, 3'd1,4'h6,4'h3, 64'h0, 64'hA, 64'hB, 16'h2F12, 0,1);
      ex[18] = X(3'd1,4'h6,4'h3, 64'h0, 64'hA, 64'hB, 16'h2F12, 64'hA, 64'hB, 2'd3, 0);
      // unrecognised icode C, HALT, JXX: pass through, ALU idle
      st[19] = S(0,0,0, 3'd3,4'hC,4'h2, 64'h12, 64'h34, 64'h56, 16'h789A, 0,0);
      ex[19] = X(3'd3,4'hC,4'h2, 64'h12, 64'h34, 64'h56, 16'h789A, 64'h0, 64'h0, 2'd0, 0);
      st[20] = S(0,0,0, 3'd4,4'h0,4'h0, 64'h1, 64'h2, 64'h3, 16'hFFFF, 0,0);
      ex[20] = X(3'd4,4'h0,4'h0, 64'h1, 64'h2, 64'h3, 16'hFFFF, 64'h0, 64'h0, 2'd0, 0);
      st[21] = S(0,0,0, 3'd1,4'h7,4'h4, 64'h200, 64'h5, 64'h6, 16'hFFFF, 0,0);
      ex[21] = X(3'd1,4'h7,4'h4, 64'h200, 64'h5, 64'h6, 16'hFFFF, 64'h0, 64'h0, 2'd0, 0);
      // reset during stall, then first edge after is a normal load
      st[22] = S(1,1,0, 3'd1,4'h6,4'h2, 64'h0, 64'h1, 64'h2, 16'h1F01, 0,0);
      ex[22] = bub_e;
      st[23] = S(0,0,0, 3'd1,4'h6,4'h2, 64'h0, 64'h1, 64'h2, 16'h1F01, 0,0);
      ex[23] = X(3'd1,4'h6,4'h2, 64'h0, 64'h1, 64'h2, 16'h1F01, 64'h1, 64'h2, 2'd2, 1);
      // reset beats stall+bubble
      st[24] = S(1,1,1, 3'd2,4'h5,4'h1, 64'h7, 64'h7, 64'h7, 16'h7777, 0,0);
      ex[24] = bub_e;

      reset = 1'b1; stall = 1'b0; bubble = 1'b0;
      d_stat = '0; d_icode = '0; d_ifun = '0;
      d_valC = '0; d_valA = '0; d_valB = '0;
      d_dstE = '0; d_dstM = '0; d_srcA = '0; d_srcB = '0;
      m_exc = 1'b0; w_exc = 1'b0;

      // Inputs change just after negedge, hold through posedge and the check
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         #1;
         reset  = st[i].rst;  stall  = st[i].stl;  bubble = st[i].bub;
         d_stat = st[i].stat; d_icode = st[i].icode; d_ifun = st[i].ifun;
         d_valC = st[i].valc; d_valA = st[i].vala; d_valB = st[i].valb;
         {d_dstE, d_dstM, d_srcA, d_srcB} = st[i].regs;
         m_exc  = st[i].mexc; w_exc = st[i].wexc;
         @(posedge clk);
         #1;
         cur = ex[i];
         cur.id = i;
         sb_q.push_back(cur);
         @(negedge clk);
      end

      // Bounded drain of the scoreboard
      for (int k = 0; k < 5 && sb_q.size() > 0; k++) @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
